cve2_obi_data_slice: RTL and testbench

CVE2_OBI_DATA_SLICE -- requirements
Module: cve2_obi_data_slice

---
 rtl/cve2_obi_data_slice.sv | 142 ++++++++++++++
 tb/tb_cve2_obi_data_slice.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_obi_data_slice.sv
`default_nettype none
// ==========================================================================
// cve2_obi_data_slice: one-entry OBI request slice with registered response
// Revision: 1.0
// ==========================================================================
module cve2_obi_data_slice #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,

  output logic        busy_o,
  output logic        protocol_err_o
);

  localparam int unsigned     CNT_W   = $clog2(MaxOutstanding + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MaxOutstanding);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             req_valid_q, req_valid_d;
  logic             req_we_q;
  logic [3:0]       req_be_q;
  logic [31:0]      req_addr_q;
  logic [31:0]      req_wdata_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             perr_q;

  logic             w_core_hs;
  logic             w_mem_hs;
  logic             w_rsp_ok;
  logic             w_rsp_spurious;
  logic             w_cnt_room;

  // Grant depends only on registered state and request-side inputs, never on mem_rvalid_i.
  assign w_cnt_room     = (cnt_q < CNT_MAX);
  assign core_gnt_o     = core_req_i & (~req_valid_q | mem_gnt_i) & w_cnt_room;
  assign w_core_hs      = core_gnt_o;
  assign w_mem_hs       = req_valid_q & mem_gnt_i;
  assign w_rsp_ok       = mem_rvalid_i & (mem_cnt_q != '0);
  assign w_rsp_spurious = mem_rvalid_i & (mem_cnt_q == '0);

  always_comb begin
    req_valid_d = req_valid_q;
    if (w_core_hs) begin
      req_valid_d = 1'b1;
    end else if (w_mem_hs) begin
      req_valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({w_core_hs, rvalid_q})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    mem_cnt_d = mem_cnt_q;
    case ({w_mem_hs, w_rsp_ok})
      2'b10:   mem_cnt_d = mem_cnt_q + CNT_ONE;
      2'b01:   mem_cnt_d = mem_cnt_q - CNT_ONE;
      default: mem_cnt_d = mem_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_be_q    <= 4'h0;
      req_addr_q  <= 32'h0;
      req_wdata_q <= 32'h0;
      cnt_q       <= '0;
      mem_cnt_q   <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      req_valid_q <= req_valid_d;
      if (w_core_hs) begin
        req_we_q    <= core_we_i;
        req_be_q    <= core_be_i;
        req_addr_q  <= core_addr_i;
        req_wdata_q <= core_wdata_i;
      end
      cnt_q     <= cnt_d;
      mem_cnt_q <= mem_cnt_d;
      // A response with nothing outstanding at memory is dropped, only flagged.
      rvalid_q  <= w_rsp_ok;
      if (w_rsp_ok) begin
        rdata_q <= mem_rdata_i;
        err_q   <= mem_err_i;
      end
      if (w_rsp_spurious) begin
        perr_q <= 1'b1;
      end
    end
  end

  assign mem_req_o      = req_valid_q;
  assign mem_we_o       = req_we_q;
  assign mem_be_o       = req_be_q;
  assign mem_addr_o     = req_addr_q;
  assign mem_wdata_o    = req_wdata_q;

  assign core_rvalid_o  = rvalid_q;
  assign core_rdata_o   = rdata_q;
  assign core_err_o     = err_q;

  assign busy_o         = (cnt_q != '0);
  assign protocol_err_o = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_cve2_obi_data_slice.sv
`default_nettype none
// ==========================================================================
// tb_cve2_obi_data_slice: scoreboard bench with transaction-level model
// Revision: 1.0
// ==========================================================================
module tb_cve2_obi_data_slice;

  localparam int MAX = 2;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        core_req_i = 1'b0;
  logic        core_we_i = 1'b0;
  logic [3:0]  core_be_i = 4'h0;
  logic [31:0] core_addr_i = 32'h0;
  logic [31:0] core_wdata_i = 32'h0;
  logic        core_gnt_o;
  logic        core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        core_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        mem_err_i = 1'b0;
  logic        busy_o;
  logic        protocol_err_o;

  always #5 clk_i = ~clk_i;

  cve2_obi_data_slice #(.MaxOutstanding(MAX)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .core_req_i     (core_req_i),
    .core_we_i      (core_we_i),
    .core_be_i      (core_be_i),
    .core_addr_i    (core_addr_i),
    .core_wdata_i   (core_wdata_i),
    .core_gnt_o     (core_gnt_o),
    .core_rvalid_o  (core_rvalid_o),
    .core_rdata_o   (core_rdata_o),
    .core_err_o     (core_err_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_err_i      (mem_err_i),
    .busy_o         (busy_o),
    .protocol_err_o (protocol_err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model state
  rsp_t exp_q[$];     // responses the core should see, in order
  req_t req_q[$];     // accepted requests not yet handed to memory
  rsp_t mem_q[$];     // responses the memory still owes
  int   tb_out     = 0;
  int   tb_mem_out = 0;
  bit   tb_rv      = 1'b0;
  bit   tb_perr    = 1'b0;
  bit   rv_vis     = 1'b0;

  // Memory contents as a pure function of the request, so expectations need no DUT readback.
  function automatic rsp_t rsp_of(input req_t r);
    rsp_t o;
    o.data = (r.addr * 32'h9E37_79B1) ^ r.wdata ^ {27'h0, r.be, r.we};
    o.err  = r.addr[4] & r.addr[3];
    return o;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.we    = 1'($urandom);
    r.be    = 4'($urandom);
    r.addr  = $urandom;
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && core_rvalid_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got response data %0h, expected none", core_rdata_o);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", 96'(core_rdata_o), 96'(e.data));
          chk("rsp_err",  96'(core_err_o),   96'(e.err));
        end
      end
    end
  end

  // One clock cycle: drive inputs, check against the model, advance the model.
  task automatic step(input bit req, input req_t p, input bit gnt, input int rvp,
                      input bit spur, output bit granted);
    rsp_t r;
    req_t h;
    bit   egnt, mhs, acc;
    @(negedge clk_i);
    rst_ni       = 1'b1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom;
    mem_err_i    = 1'($urandom);
    if (spur) begin
      mem_rvalid_i = 1'b1;
    end else if (mem_q.size() > 0 && int'($urandom_range(99)) < rvp) begin
      r            = mem_q.pop_front();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = r.data;
      mem_err_i    = r.err;
    end
    core_req_i   = req;
    core_we_i    = p.we;
    core_be_i    = p.be;
    core_addr_i  = p.addr;
    core_wdata_i = p.wdata;
    mem_gnt_i    = gnt;
    #1;
    egnt = req && (!tb_rv || gnt) && (tb_out < MAX);
    chk("core_gnt",     96'(core_gnt_o),     96'(egnt));
    chk("mem_req",      96'(mem_req_o),      96'(tb_rv));
    chk("busy",         96'(busy_o),         96'(tb_out != 0));
    chk("core_rvalid",  96'(core_rvalid_o),  96'(rv_vis));
    chk("protocol_err", 96'(protocol_err_o), 96'(tb_perr));
    mhs = tb_rv && gnt;
    if (mhs) begin
      if (req_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mem_hs_model: got memory handshake, expected none pending");
      end else begin
        h = req_q.pop_front();
        chk("mem_payload", 96'({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}), 96'(h));
        mem_q.push_back(rsp_of(h));
      end
    end
    acc = mem_rvalid_i && (tb_mem_out > 0);
    if (mem_rvalid_i && tb_mem_out == 0) tb_perr = 1'b1;
    tb_mem_out = tb_mem_out + int'(mhs) - int'(acc);
    if (egnt) begin
      req_q.push_back(p);
      exp_q.push_back(rsp_of(p));
      tb_rv = 1'b1;
    end else if (mhs) begin
      tb_rv = 1'b0;
    end
    tb_out  = tb_out + int'(egnt) - int'(rv_vis);
    rv_vis  = acc;
    granted = egnt;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk_i);
    rst_ni       = 1'b0;
    core_req_i   = 1'b1;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    #1;
    chk("rst_mem_req",   96'(mem_req_o), 96'(0));
    chk("rst_mem_pay",   96'({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}), 96'(0));
    chk("rst_rsp",       96'({core_rvalid_o, core_err_o, core_rdata_o}), 96'(0));
    chk("rst_busy",      96'(busy_o), 96'(0));
    chk("rst_perr",      96'(protocol_err_o), 96'(0));
    chk("rst_gnt",       96'(core_gnt_o), 96'(1));
    exp_q.delete();
    req_q.delete();
    mem_q.delete();
    tb_out = 0; tb_mem_out = 0; tb_rv = 1'b0; tb_perr = 1'b0; rv_vis = 1'b0;
    repeat (cycles - 1) @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    bit g;
    req_t z;
    z = '0;
    repeat (n) step(1'b0, z, 1'b1, 100, 1'b0, g);
  endtask

  task automatic issue(input req_t p, input bit gnt, input int rvp);
    bit g;
    g = 1'b0;
    for (int t = 0; t < 40 && !g; t++) step(1'b1, p, gnt, rvp, 1'b0, g);
    if (!g) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: got no grant for addr %0h, expected one within 40 cycles", p.addr);
    end
  endtask

  initial begin
    req_t p, p2;
    bit   g, pend;
    int   gnt_cnt;

    do_reset(3);

    // Single write with minimum latency
    p = '{we: 1'b1, be: 4'hF, addr: 32'h1000_0040, wdata: 32'hDEAD_BEEF};
    step(1'b1, p, 1'b1, 100, 1'b0, g);
    chk("single_gnt", 96'(g), 96'(1));
    idle(5);

    // Back-to-back reads
    for (int i = 0; i < 4; i++) begin
      p = '{we: 1'b0, be: 4'hF, addr: 32'(i * 4), wdata: 32'h0};
      issue(p, 1'b1, 100);
    end
    idle(6);

    // Memory stall with the core request held
    p  = '{we: 1'b1, be: 4'h3, addr: 32'h2000_0100, wdata: 32'h1234_5678};
    p2 = '{we: 1'b0, be: 4'hF, addr: 32'h2000_0104, wdata: 32'h0};
    step(1'b1, p, 1'b0, 100, 1'b0, g);
    gnt_cnt = int'(g);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, p2, 1'b0, 100, 1'b0, g);
      gnt_cnt += int'(g);
      chk("stall_payload", 96'({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}), 96'(p));
    end
    chk("stall_grants", 96'(gnt_cnt), 96'(1));
    issue(p2, 1'b1, 100);
    idle(6);

    // Outstanding limit with responses withheld, then released
    for (int i = 0; i < 4; i++) step(1'b1, rnd_req(), 1'b1, 0, 1'b0, g);
    for (int i = 0; i < 4; i++) step(1'b1, rnd_req(), 1'b1, 100, 1'b0, g);
    idle(6);

    // Error response and spurious memory response
    p = '{we: 1'b0, be: 4'hF, addr: 32'h0000_0018, wdata: 32'h0};
    issue(p, 1'b1, 100);
    idle(5);
    step(1'b0, p, 1'b1, 0, 1'b1, g);
    idle(2);
    chk("perr_sticky", 96'(protocol_err_o), 96'(1));

    // Reset with two transactions in flight
    step(1'b1, rnd_req(), 1'b1, 0, 1'b0, g);
    step(1'b1, rnd_req(), 1'b1, 0, 1'b0, g);
    chk("burst_outstanding", 96'(tb_out), 96'(2));
    do_reset(2);
    p = rnd_req();
    step(1'b1, p, 1'b1, 100, 1'b0, g);
    chk("gnt_after_reset", 96'(g), 96'(1));
    idle(5);

    // Randomized traffic, requests held until granted
    pend = 1'b0;
    p    = '0;
    for (int c = 0; c < 800; c++) begin
      if (!pend && $urandom_range(99) < 70) begin
        p    = rnd_req();
        pend = 1'b1;
      end
      step(pend, p, ($urandom_range(99) < 70), int'($urandom_range(100)), 1'b0, g);
      if (g) pend = 1'b0;
    end

    // Drain
    for (int t = 0; t < 60 && (exp_q.size() != 0 || tb_out != 0 || mem_q.size() != 0); t++) idle(1);
    idle(2);
    chk("drain_scoreboard", 96'(exp_q.size()), 96'(0));
    chk("drain_busy", 96'(busy_o), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
